// File: rtl/psum_ofifo_pkg.sv
// Shared sizing for the mac_array south-edge datapath: array width, psum word
// width and output FIFO depth.
package psum_ofifo_pkg;

    localparam int COL         = 8;
    localparam int PSUM_BW     = 16;
    localparam int OFIFO_DEPTH = 64;
    localparam int OFIFO_PTR_W = $clog2(OFIFO_DEPTH) + 1;

endpackage

// File: rtl/ofifo_lane.sv
// One psum column lane: single-clock circular buffer with wrap-bit pointers.
// Reports a dropped write instead of flagging it itself.
module ofifo_lane #(
    parameter int width = 16,
    parameter int depth = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic [width-1:0] in,
    input  logic             pop,
    output logic [width-1:0] head,
    output logic             empty,
    output logic             full,
    output logic             drop
);

    localparam int aw = $clog2(depth);

    logic [aw:0]      wptr;
    logic [aw:0]      rptr;
    logic [width-1:0] mem [depth];
    logic             accept;

    assign empty = (wptr == rptr);
    assign full  = (wptr[aw-1:0] == rptr[aw-1:0]) && (wptr[aw] != rptr[aw]);

    // A write into a full lane is legal only when the same edge frees the head slot.
    assign accept = wr && (!full || pop);
    assign drop   = wr && full && !pop;

    assign head = mem[rptr[aw-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of always_ff ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (accept) wptr <= wptr + (aw+1)'(1);
            if (pop)    rptr <= rptr + (aw+1)'(1);
        end
    end

    // NOTE: storage is deliberately left out of reset; emptiness is defined by
    // the pointers alone, so stale contents are never observable.
    always_ff @(posedge clk) begin
        if (accept) mem[wptr[aw-1:0]] <= in;
    end

endmodule

// File: rtl/psum_ofifo.sv
// South-edge psum collector: one FIFO lane per mac_array column, releasing a
// full row only when every lane holds data.
module psum_ofifo
    import psum_ofifo_pkg::*;
#(
    parameter int col     = COL,
    parameter int psum_bw = PSUM_BW,
    parameter int depth   = OFIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [psum_bw*col-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready,
    output logic                   o_overflow
);

    logic [col-1:0]         empty;
    logic [col-1:0]         full;
    logic [col-1:0]         drop;
    logic [psum_bw*col-1:0] head_row;
    logic                   pop;

    for (genvar k = 0; k < col; k++) begin : g_lane
        ofifo_lane #(
            .width (psum_bw),
            .depth (depth)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .wr    (wr[k]),
            .in    (in[k*psum_bw +: psum_bw]),
            .pop   (pop),
            .head  (head_row[k*psum_bw +: psum_bw]),
            .empty (empty[k]),
            .full  (full[k]),
            .drop  (drop[k])
        );
    end

    // Flags depend on pointer state only, so upstream handshakes never form a loop.
    assign o_valid = &(~empty);
    assign o_full  = |full;
    assign o_ready = ~o_full;

    // Lanes only advance together, so gating pop with o_valid keeps every lane
    // from popping while empty.
    assign pop = rd && o_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out        <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (pop)   out        <= head_row;
            if (|drop) o_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_psum_ofifo.sv
// Self-checking bench for psum_ofifo against a per-lane queue model.
module tb_psum_ofifo;
    import psum_ofifo_pkg::*;

    localparam int C = COL;
    localparam int W = PSUM_BW;
    localparam int D = OFIFO_DEPTH;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [W*C-1:0] in_bus = '0;
    logic [C-1:0]   wr = '0;
    logic           rd = 1'b0;
    logic [W*C-1:0] out_bus;
    logic           o_valid, o_full, o_ready, o_overflow;

    int errors = 0;
    int checks = 0;

    // Behavioural model: one queue per column, plus the output row and sticky flag.
    logic [W-1:0]   mq [C][$];
    logic [W*C-1:0] m_out = '0;
    logic           m_ovf = 1'b0;
    logic           m_popped = 1'b0;

    psum_ofifo dut (
        .clk        (clk),
        .reset      (reset),
        .in         (in_bus),
        .wr         (wr),
        .rd         (rd),
        .out        (out_bus),
        .o_valid    (o_valid),
        .o_full     (o_full),
        .o_ready    (o_ready),
        .o_overflow (o_overflow)
    );

    always #5 clk = ~clk;

    function automatic logic m_valid();
        for (int k = 0; k < C; k++) if (mq[k].size() == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic m_full();
        for (int k = 0; k < C; k++) if (mq[k].size() == D) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [W*C-1:0] rand_row();
        logic [W*C-1:0] r;
        for (int k = 0; k < C; k++) r[k*W +: W] = W'($urandom);
        return r;
    endfunction

    function automatic logic [W*C-1:0] same_row(input logic [W-1:0] v);
        logic [W*C-1:0] r;
        for (int k = 0; k < C; k++) r[k*W +: W] = v;
        return r;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < C; k++) mq[k].delete();
        m_out = '0;
        m_ovf = 1'b0;
    endtask

    // Drive one cycle of stimulus, advance the model at the edge, settle 1 time unit.
    task automatic step(input logic [C-1:0] w, input logic [W*C-1:0] d, input logic r);
        logic p;
        wr = w;
        in_bus = d;
        rd = r;
        @(posedge clk);
        p = r && m_valid();
        m_popped = p;
        if (p) for (int k = 0; k < C; k++) m_out[k*W +: W] = mq[k].pop_front();
        for (int k = 0; k < C; k++) begin
            if (w[k]) begin
                if (mq[k].size() < D) mq[k].push_back(d[k*W +: W]);
                else m_ovf = 1'b1;
            end
        end
        #1;
        wr = '0;
        rd = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (out_bus !== '0) begin errors++; $display("FAIL reset_out: got %h want 0", out_bus); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", o_full); end
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", o_ready); end
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", o_overflow); end
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            step('0, rand_row(), 1'b1);
            checks++;
            if (out_bus !== '0 || o_valid !== 1'b0 || o_full !== 1'b0 || o_ready !== 1'b1 || o_overflow !== 1'b0) begin
                errors++;
                $display("FAIL idle_rd%0d: out=%h v=%b f=%b r=%b ovf=%b want 0/0/0/1/0",
                         i, out_bus, o_valid, o_full, o_ready, o_overflow);
            end
        end
    endtask

    task automatic test_skewed_fill();
        logic [W*C-1:0] d;
        logic [W*C-1:0] want;
        apply_reset();
        for (int k = 0; k < C; k++) begin
            d = rand_row();
            d[k*W +: W] = W'(16'h0100 + k);
            want[k*W +: W] = W'(16'h0100 + k);
            step(C'(1) << k, d, 1'b0);
            checks++;
            if (o_valid !== (k == C-1)) begin
                errors++;
                $display("FAIL skew_valid_k%0d: got %b want %b", k, o_valid, (k == C-1));
            end
        end
        step('0, rand_row(), 1'b1);
        checks++; if (out_bus !== want) begin errors++; $display("FAIL skew_row: got %h want %h", out_bus, want); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL skew_drained: got %b want 0", o_valid); end
    endtask

    task automatic test_stream();
        int next_r = 0;
        apply_reset();
        for (int r = 0; r < 100 + 4; r++) begin
            step(r < 100 ? '1 : '0, same_row(W'(r)), 1'b1);
            if (m_popped) begin
                checks++;
                if (out_bus !== same_row(W'(next_r))) begin
                    errors++;
                    $display("FAIL stream_row%0d: got %h want %h", next_r, out_bus, same_row(W'(next_r)));
                end
                next_r++;
            end
        end
        checks++; if (next_r != 100) begin errors++; $display("FAIL stream_count: got %0d want 100", next_r); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL stream_empty: got %b want 0", o_valid); end
    endtask

    task automatic test_full_overflow();
        apply_reset();
        for (int i = 0; i < D; i++) step('1, rand_row(), 1'b0);
        checks++; if (o_full !== 1'b1) begin errors++; $display("FAIL full_flag: got %b want 1", o_full); end
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", o_ready); end
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL full_no_ovf: got %b want 0", o_overflow); end
        step(C'(8), rand_row(), 1'b0);
        checks++; if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", o_overflow); end
        step(C'(1), rand_row(), 1'b1);
        checks++; if (out_bus !== m_out) begin errors++; $display("FAIL ovf_pop_row: got %h want %h", out_bus, m_out); end
        checks++; if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", o_overflow); end
        checks++; if (o_full !== 1'b1) begin errors++; $display("FAIL lane0_refull: got %b want 1", o_full); end
        // Drain; the lane-3 column of every row proves the dropped write left no trace.
        for (int i = 0; i < 2*D && m_valid(); i++) begin
            step('0, rand_row(), 1'b1);
            checks++;
            if (out_bus !== m_out || o_full !== m_full() || o_valid !== m_valid()) begin
                errors++;
                $display("FAIL drain%0d: out=%h f=%b v=%b want out=%h f=%b v=%b",
                         i, out_bus, o_full, o_valid, m_out, m_full(), m_valid());
            end
        end
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL drained_ready: got %b want 1", o_ready); end
    endtask

    task automatic test_mid_reset();
        logic [W*C-1:0] row;
        apply_reset();
        for (int i = 0; i < 10; i++) step('1, rand_row(), 1'b0);
        step('0, rand_row(), 1'b1);
        step(C'(8), rand_row(), 1'b0);
        for (int i = 0; i < D; i++) step(C'(8), rand_row(), 1'b0);
        checks++; if (o_overflow !== 1'b1 || out_bus === '0) begin
            errors++; $display("FAIL pre_reset: ovf=%b out=%h want ovf=1 out!=0", o_overflow, out_bus);
        end
        #3;
        reset = 1'b1;
        #1;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL async_valid: got %b want 0", o_valid); end
        checks++; if (out_bus !== '0) begin errors++; $display("FAIL async_out: got %h want 0", out_bus); end
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL async_ovf: got %b want 0", o_overflow); end
        #2;
        reset = 1'b0;
        model_clear();
        row = rand_row();
        step('1, row, 1'b0);
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL post_reset_valid: got %b want 1", o_valid); end
        step('0, rand_row(), 1'b1);
        checks++; if (out_bus !== row) begin errors++; $display("FAIL post_reset_row: got %h want %h", out_bus, row); end
    endtask

    task automatic test_random();
        int bad = 0;
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            step(C'($urandom), rand_row(), ($urandom_range(0, 99) < 40));
            checks++;
            if (out_bus !== m_out || o_valid !== m_valid() || o_full !== m_full() ||
                o_ready !== !m_full() || o_overflow !== m_ovf) begin
                errors++;
                if (bad < 10)
                    $display("FAIL rand%0d: out=%h v=%b f=%b r=%b ovf=%b want out=%h v=%b f=%b r=%b ovf=%b",
                             i, out_bus, o_valid, o_full, o_ready, o_overflow,
                             m_out, m_valid(), m_full(), !m_full(), m_ovf);
                bad++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_skewed_fill();
        test_stream();
        test_full_overflow();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/psum_ofifo.md
# psum_ofifo

Output collector on the south edge of `mac_array`. It captures the per-column partial sums that `mac_array` drives on `out_s` whenever the matching `valid` bit pulses. Columns finish at skewed cycles, so each column lands in its own FIFO lane. The block releases one full row of `col` psums to the downstream reader (SFU / psum SRAM writer) only when every lane holds data.

## Interface

Parameters:
- `col`, 8, number of array columns, one FIFO lane each.
- `psum_bw`, 16, width of one psum word.
- `depth`, 64, entries per lane; power of two, minimum 2.

Ports:
- `clk`  input  1  single clock.
- `reset`  input  1  asynchronous, active-high; clears all state.
- `in`  input  `psum_bw*col`  column psums; connects to `mac_array.out_s`; column k at bits `[psum_bw*(k+1)-1 : psum_bw*k]`.
- `wr`  input  `col`  per-column write strobe; connects to `mac_array.valid`.
- `rd`  input  1  pop one entry from every lane; honoured only while `o_valid`.
- `out`  output  `psum_bw*col`  registered popped row, same packing as `in`.
- `o_valid`  output  1  every lane holds at least one entry.
- `o_full`  output  1  at least one lane holds `depth` entries.
- `o_ready`  output  1  equals `~o_full`; upstream stalls `inst_w` execute while low.
- `o_overflow`  output  1  sticky; set when a write is dropped; cleared only by `reset`.

## Operation

- Each lane k is an independent circular buffer with:
  - write pointer and read pointer, each `$clog2(depth)+1` bits; the MSB is the wrap bit;
  - empty when the pointers are equal;
  - full when the low bits are equal and the MSBs differ.
- Write, lane k: `wr[k]` at a posedge stores `in[k]` at the write pointer and increments it.
- Effective pop: `pop = rd & o_valid`. On a posedge, every lane advances its read pointer, and `out` loads all lane heads from before that edge.
- If `rd` is high while `o_valid` is low, the request is ignored: no pointer moves, `out` holds, no error flag.
- Write to a full lane:
  - with `pop` in the same cycle: accepted, occupancy stays `depth`;
  - without `pop`: dropped, pointers unchanged, `o_overflow` set.
- Write to an empty lane together with `pop`: cannot happen, because `pop` requires every lane non-empty.
- `o_valid`, `o_full` and `o_ready` are combinational from the pointer state only, never from `in`/`wr`/`rd`.
- Lanes have no ordering dependence. Each lane's entry i pairs with every other lane's entry i to form output row i.
- Pointers wrap silently modulo `2*depth`.

## Timing

- Reset values: `out=0`, `o_valid=0`, `o_full=0`, `o_ready=1`, `o_overflow=0`, all pointers 0. Memory contents are don't-care.
- Reset asserted mid-operation drops all stored data immediately, asynchronously. The first write is accepted at the first posedge after `reset` deasserts.
- Write-to-visible latency: a write at edge N makes the lane non-empty after N. `o_valid` can rise in the cycle following N.
- Read latency: `rd` sampled high at edge M with `o_valid` high gives the row on `out` after M. `out` holds until the next effective pop.
- Back-to-back pops: `rd` high every cycle drains one row per cycle while `o_valid` stays high.
- `o_full` deasserts in the cycle after the pop that frees the last full lane.

## Structure

- Sub-module `ofifo_lane`: one single-clock FIFO with parameters `width` and `depth`. Ports: `clk`, `reset`, `wr`, `in`, `pop`, `head`, `empty`, `full`, `drop`.
- `psum_ofifo` instantiates `col` lanes in a generate loop, ANDs the `~empty` flags into `o_valid`, ORs the `full` flags into `o_full`, and owns the `out` register and the sticky `o_overflow`.
- The shared parameter package holds the defaults `COL=8`, `PSUM_BW=16`, `OFIFO_DEPTH=64`, and the derived pointer width `OFIFO_PTR_W = $clog2(OFIFO_DEPTH)+1`. `mac_array` and `psum_ofifo` instances take `col` and `psum_bw` from it.

## Test plan

- Reset then idle: check `out=0`, `o_valid=0`, `o_full=0`, `o_ready=1`. Pulse `rd` 3 times; `out` stays 0 and no flag changes.
- Skewed fill: drive `wr[k]` at cycle k (k=0..7) with column k value `16'h0100+k`. `o_valid` rises only the cycle after `wr[7]`. `rd` one cycle gives `out = {16'h0107,…,16'h0100}` on the next edge.
- Stream: write rows r=0..99 with all-column value r. Hold `rd` high continuously, reading in order. Every popped row equals the next r in order, with no gaps; the pointers wrap past 64 cleanly.
- Full/overflow: write 64 rows with `rd=0`; `o_full=1`, `o_ready=0`. A 65th write on lane 3 only sets `o_overflow=1` and does not change lane 3 contents. Then `rd` plus a lane-0 write in the same cycle is accepted and `o_overflow` stays 1.
- Mid-operation reset: with 10 rows stored, pulse `reset` asynchronously between edges. Immediately check `o_valid=0`, `out=0`, `o_overflow=0`. Write a new row and read it back exactly.
